// File: rtl/batt_mon_if.sv
// Battery monitor port bundle: raw A2D sample in; moving average and the
// low-battery flag out.
//
// Handshake: batt_vld is a one-cycle valid strobe and has no ready. The
// monitor accepts every strobe, including one on every cycle, so a sample
// is taken on each rising edge where batt_vld is high. batt_avg, avg_vld and
// batt_low are registered levels that stay put between strobes.
interface batt_mon_if;
  logic [11:0] batt;
  logic        batt_vld;
  logic [11:0] batt_avg;
  logic        avg_vld;
  logic        batt_low;

  modport master (
    output batt, batt_vld,
    input  batt_avg, avg_vld, batt_low
  );

  modport slave (
    input  batt, batt_vld,
    output batt_avg, avg_vld, batt_low
  );
endinterface

// File: rtl/batt_mon.sv
// Battery monitor. It keeps an 8-sample moving average of the A2D battery
// readings and raises a low-battery flag. The flag has hysteresis and a
// persistence filter.
// state_dbg exposes the FSM state: 0 = FILL, 1 = OK, 2 = LOW.
module batt_mon #(
  parameter logic [11:0] LOW_THRESH = 12'h800,
  parameter logic [11:0] HYST       = 12'h040,
  parameter int unsigned PERSIST    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  batt_mon_if.slave   bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_OK   = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // The recovery level is 13 bits wide. If it is above 4095, no 12-bit
  // average can reach it, so LOW is never left.
  localparam logic [12:0] EXIT_THRESH = {1'b0, LOW_THRESH} + {1'b0, HYST};
  localparam logic [2:0]  PERSIST_C   = 3'(PERSIST);

  logic [11:0] sbuf [8];
  logic [14:0] sum;
  logic [14:0] sum_nxt;
  logic [2:0]  wr_ptr;
  logic [3:0]  fill_cnt;
  logic        upd;
  logic [11:0] avg_q;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  pcnt;
  logic [2:0]  pcnt_nxt;
  logic [2:0]  pcnt_inc;
  logic        low_q;

  // Running sum: the new sample goes in and the oldest entry, read before
  // it is overwritten, comes out.
  always_comb begin
    sum_nxt = sum + {3'b000, bus.batt} - {3'b000, sbuf[wr_ptr]};
  end

  // Sample buffer, running sum and registered average. upd marks the cycle
  // after each accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) sbuf[i] <= '0;
      sum      <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      upd      <= 1'b0;
      avg_q    <= '0;
    end else begin
      upd <= bus.batt_vld;
      if (bus.batt_vld) begin
        sbuf[wr_ptr] <= bus.batt;
        wr_ptr       <= wr_ptr + 3'd1;
        sum          <= sum_nxt;
        avg_q        <= sum_nxt[14:3];
        if (fill_cnt != 4'd8) fill_cnt <= fill_cnt + 4'd1;
      end
    end
  end

  assign pcnt_inc = pcnt + 3'd1;

  // Next state and persistence count. A threshold check runs only on upd.
  // The upd that ends FILL is only a hand-over, so it is not checked.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    case (state)
      ST_FILL: begin
        if (upd && (fill_cnt == 4'd8)) begin
          state_nxt = ST_OK;
          pcnt_nxt  = 3'd0;
        end
      end
      ST_OK: begin
        if (upd) begin
          if (avg_q < LOW_THRESH) begin
            if (pcnt_inc == PERSIST_C) begin
              state_nxt = ST_LOW;
              pcnt_nxt  = 3'd0;
            end else begin
              pcnt_nxt = pcnt_inc;
            end
          end else begin
            pcnt_nxt = 3'd0;
          end
        end
      end
      ST_LOW: begin
        if (upd) begin
          if ({1'b0, avg_q} >= EXIT_THRESH) begin
            if (pcnt_inc == PERSIST_C) begin
              state_nxt = ST_OK;
              pcnt_nxt  = 3'd0;
            end else begin
              pcnt_nxt = pcnt_inc;
            end
          end else begin
            pcnt_nxt = 3'd0;
          end
        end
      end
      default: begin
        state_nxt = ST_FILL;
        pcnt_nxt  = 3'd0;
      end
    endcase
  end

  // State register. batt_low follows the next state, so it changes on the
  // same edge as the transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FILL;
      pcnt  <= 3'd0;
      low_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
      low_q <= (state_nxt == ST_LOW);
    end
  end

  assign bus.batt_avg = avg_q;
  assign bus.avg_vld  = (fill_cnt == 4'd8);
  assign bus.batt_low = low_q;
  assign state_dbg    = state;

endmodule

// File: doc/batt_mon.md
BATT_MON -- requirements
Module: batt_mon

Interface
REQ-001 Parameter LOW_THRESH, default 12'h800: averaged battery level below which the battery counts as low.
REQ-002 Parameter HYST, default 12'h040: recovery margin; the low flag clears only at avg >= LOW_THRESH+HYST.
REQ-003 Parameter PERSIST, default 4 (range 1-7): consecutive qualifying averages needed to change state.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 batt  input  12  raw battery conversion from the A2D interface, unsigned.
REQ-007 batt_vld  input  1  one-cycle strobe; batt is valid this cycle.
REQ-008 batt_avg  output  12  registered 8-sample moving average.
REQ-009 avg_vld  output  1  high once 8 samples have been accepted since reset.
REQ-010 batt_low  output  1  registered, hysteretic, persistence-filtered low-battery flag (drives piezo batt_low).

Function
REQ-011 8-entry circular sample buffer; on batt_vld: buf[wr_ptr]<=batt, wr_ptr<=wr_ptr+1 (3-bit, 7 wraps to 0).
REQ-012 15-bit running sum; on batt_vld: sum<=sum+batt-buf[wr_ptr] (old entry read before overwrite); no overflow possible.
REQ-013 batt_avg = sum[14:3] (truncating divide by 8), visible the cycle after the batt_vld edge.
REQ-014 fill_cnt 4-bit, increments on batt_vld, saturates at 8; avg_vld = (fill_cnt==8), registered, never deasserts until reset.
REQ-015 Internal upd pulse registered one cycle after each accepted batt_vld; threshold evaluation occurs only on upd.
REQ-016 FSM states FILL, OK, LOW; 3-bit persistence counter pcnt.
REQ-017 FILL: batt_low=0, no evaluation; on upd with fill_cnt==8 -> OK with pcnt=0, and that upd is not evaluated.
REQ-018 OK: on upd, avg<LOW_THRESH -> pcnt+1, else pcnt=0; when incremented pcnt equals PERSIST -> LOW, pcnt=0.
REQ-019 LOW: on upd, avg>=LOW_THRESH+HYST -> pcnt+1, else pcnt=0; when incremented pcnt equals PERSIST -> OK, pcnt=0.
REQ-020 Averages in [LOW_THRESH, LOW_THRESH+HYST) reset pcnt in both OK and LOW; state holds.
REQ-021 batt_low registered = (next state==LOW); asserts on the same edge as the transition, 2 cycles after the qualifying batt_vld.
REQ-022 Back-to-back batt_vld every cycle supported; each sample updates sum and is evaluated once; none dropped.
REQ-023 No batt_vld: all state, sum, outputs hold indefinitely.
REQ-024 LOW_THRESH+HYST computed 13-bit; if >4095, LOW is never exited (defined behaviour, not error).

Reset
REQ-025 rst_n low at a clock edge: buffer entries, sum, wr_ptr, fill_cnt, pcnt, upd cleared to 0; state=FILL; batt_avg=0, avg_vld=0, batt_low=0.
REQ-026 Reset overrides batt_vld in the same cycle; sample discarded.
REQ-027 Reset mid-operation (any state) returns to FILL; 8 new samples required before batt_low can assert.

Verification
REQ-028 Fill: 8 samples of 12'hA00 -> avg_vld rises cycle after 8th strobe, batt_avg=12'hA00, batt_low=0 throughout.
REQ-029 Wrap: 8x12'hA00 then 8x12'h400 -> batt_avg steps by 12'h0C0 per sample to 12'h400; batt_low rises 2 cycles after the 4th strobe whose avg<12'h800.
REQ-030 Hysteresis: in LOW, averages held at 12'h820 for 20 samples -> batt_low stays 1; then avg 12'h840 for 4 samples -> batt_low falls on 4th evaluation.
REQ-031 Persistence glitch: in OK, 3 averages 12'h7F0 then one 12'h900, repeated -> batt_low never asserts.
REQ-032 Back-to-back strobes each cycle with alternating 12'hFFF/12'h000 -> sum never exceeds 15 bits, batt_avg settles at 12'h7FF after fill.
REQ-033 Reset asserted while LOW with batt_vld high -> next cycle all outputs 0, state FILL; sample ignored.
